// File: rtl/rsa_core_arbiter.sv
// Two-requester front end for one shared modular-exponentiation core.
// Define RSA_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority to req0.
module rsa_core_arbiter #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             avm_clk,
  input  logic             avm_rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_e,
  input  logic [WIDTH-1:0] req0_n,
  output logic             req0_done,
  output logic [WIDTH-1:0] req0_result,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_e,
  input  logic [WIDTH-1:0] req1_n,
  output logic             req1_done,
  output logic [WIDTH-1:0] req1_result,

  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_e,
  output logic [WIDTH-1:0] core_n,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_finished,

  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t state, state_nx;
  logic   win;
  logic   accept;

  assign accept = (state == IDLE) && (req0_valid || req1_valid);

`ifdef RSA_ARB_ROUND_ROBIN_EN
  logic last;

  // Contention goes to whoever was not served last; a lone valid always wins.
  always_comb begin
    win = req1_valid;
    if (req0_valid && req1_valid) win = ~last;
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)     last <= 1'b1;
    else if (accept) last <= win;
  end
`else
  always_comb begin
    win = req1_valid && !req0_valid;
  end
`endif

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (core_finished) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    core_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !win;
        req1_ready = req1_valid && win;
      end
      LAUNCH: core_start = 1'b1;
      DONE: begin
        req0_done = !grant_id;
        req1_done = grant_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      core_a      <= '0;
      core_e      <= '0;
      core_n      <= '0;
      grant_id    <= 1'b0;
      req0_result <= '0;
      req1_result <= '0;
    end else begin
      if (accept) begin
        grant_id <= win;
        core_a   <= win ? req1_a : req0_a;
        core_e   <= win ? req1_e : req0_e;
        core_n   <= win ? req1_n : req0_n;
      end
      if (state == RUN && core_finished) begin
        if (grant_id) req1_result <= core_result;
        else          req0_result <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Self-checking bench for rsa_core_arbiter with a behavioural modexp core model.
// Expected grant order under contention follows RSA_ARB_ROUND_ROBIN_EN.
module tb_rsa_core_arbiter;

  localparam int unsigned W = 256;
  localparam int unsigned CORE_LAT = 10;

  logic         avm_clk = 1'b0;
  logic         avm_rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready, req0_done, req1_done;
  logic [W-1:0] req0_a = '0, req0_e = '0, req0_n = '0;
  logic [W-1:0] req1_a = '0, req1_e = '0, req1_n = '0;
  logic [W-1:0] req0_result, req1_result;
  logic         core_start, core_finished, busy, grant_id;
  logic [W-1:0] core_a, core_e, core_n, core_result;

  logic         cm_fin, spur_fin = 1'b0, cm_active;
  logic [W-1:0] cm_res;
  int           cm_cnt;
  int           starts = 0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           req;
    logic [W-1:0] a, e, n, exp;
  } vec_t;
  vec_t vecs[6];

  always #5 avm_clk = ~avm_clk;

  rsa_core_arbiter #(.WIDTH(W)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_e(req0_e), .req0_n(req0_n),
    .req0_done(req0_done), .req0_result(req0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_e(req1_e), .req1_n(req1_n),
    .req1_done(req1_done), .req1_result(req1_result),
    .core_start(core_start), .core_a(core_a), .core_e(core_e), .core_n(core_n),
    .core_result(core_result), .core_finished(core_finished),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
    longint unsigned r, b, ee, nn;
    nn = n[63:0];
    if (nn == 0) return '0;
    r  = 1 % nn;
    b  = a[63:0] % nn;
    ee = e[63:0];
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % nn;
      b  = (b * b) % nn;
      ee = ee >> 1;
    end
    return W'(r);
  endfunction

  // Core model: finished pulses CORE_LAT cycles after start; spur_fin injects stray pulses with junk data.
  always @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      cm_active <= 1'b0;
      cm_fin    <= 1'b0;
      cm_cnt    <= 0;
      cm_res    <= '0;
    end else begin
      cm_fin <= 1'b0;
      if (core_start) begin
        cm_active <= 1'b1;
        cm_cnt    <= CORE_LAT;
        cm_res    <= modexp(core_a, core_e, core_n);
      end else if (cm_active) begin
        if (cm_cnt == 1) begin
          cm_fin    <= 1'b1;
          cm_active <= 1'b0;
        end
        cm_cnt <= cm_cnt - 1;
      end
    end
  end

  assign core_finished = cm_fin | spur_fin;
  assign core_result   = spur_fin ? W'(64'hBAD0_BAD0) : cm_res;

  always @(posedge avm_clk) if (core_start) starts <= starts + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input vec_t v, input logic vld);
    if (k == 0) begin
      req0_valid = vld; req0_a = v.a; req0_e = v.e; req0_n = v.n;
    end else begin
      req1_valid = vld; req1_a = v.a; req1_e = v.e; req1_n = v.n;
    end
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((k == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge avm_clk);
    end
    if (!ok) chk("ready_timeout", W'(0), W'(1));
  endtask

  task automatic wait_done(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge avm_clk);
      if ((k == 0) ? req1_done : req0_done) chk("wrong_done", W'(1), W'(0));
      if ((k == 0) ? req0_done : req1_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", W'(0), W'(1));
  endtask

  task automatic run_job(input int k, input vec_t v, input bit spur_launch);
    logic [W-1:0] other_res, own_res;
    bit ok;
    int s0;
    @(negedge avm_clk);
    drive(k, v, 1'b1);
    wait_ready(k, ok);
    if (!ok) begin
      drive(k, v, 1'b0);
      return;
    end
    chk("other_ready_low", W'((k == 0) ? req1_ready : req0_ready), W'(0));
    other_res = (k == 0) ? req1_result : req0_result;
    own_res   = (k == 0) ? req0_result : req1_result;
    s0 = starts;
    @(negedge avm_clk);
    drive(k, v, 1'b0);
    chk("launch_core_start", W'(core_start), W'(1));
    chk("launch_grant_id", W'(grant_id), W'(k));
    chk("launch_core_a", core_a, v.a);
    chk("launch_core_e", core_e, v.e);
    chk("launch_core_n", core_n, v.n);
    chk("launch_ready_low", W'((k == 0) ? req0_ready : req1_ready), W'(0));
    if (spur_launch) begin
      spur_fin = 1'b1;
      @(negedge avm_clk);
      spur_fin = 1'b0;
      chk("spur_launch_busy", W'(busy), W'(1));
      chk("spur_launch_no_start", W'(core_start), W'(0));
      chk("spur_launch_no_done", W'(req0_done | req1_done), W'(0));
      chk("spur_launch_result", (k == 0) ? req0_result : req1_result, own_res);
    end
    wait_done(k, ok);
    if (ok) begin
      chk("job_result", (k == 0) ? req0_result : req1_result, v.exp);
      chk("other_result_held", (k == 0) ? req1_result : req0_result, other_res);
    end
    @(negedge avm_clk);
    chk("post_done_idle", W'(busy), W'(0));
    chk("done_one_cycle", W'(req0_done | req1_done), W'(0));
    chk("one_start_per_job", W'(starts - s0), W'(1));
  endtask

  task automatic pulse_reset();
    @(negedge avm_clk);
    avm_rst = 1'b1;
    @(negedge avm_clk);
    avm_rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r0, r1;
    bit ok;
    int d;
    int order[$];
    int exp_order[6];
    int idx[2];
    int dn[2];

    vecs[0] = '{0, W'(4),  W'(13), W'(497),  W'(445)};
    vecs[1] = '{1, W'(2),  W'(10), W'(1000), W'(24)};
    vecs[2] = '{0, W'(3),  W'(5),  W'(7),    W'(5)};
    vecs[3] = '{1, W'(5),  W'(3),  W'(13),   W'(8)};
    vecs[4] = '{0, W'(7),  W'(2),  W'(10),   W'(9)};
    vecs[5] = '{1, W'(10), W'(0),  W'(7),    W'(1)};

    // Reset state, checked while reset is held and after release
    repeat (2) @(negedge avm_clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_core_start", W'(core_start), W'(0));
    avm_rst = 1'b0;
    @(negedge avm_clk);
    chk("rst_grant_id", W'(grant_id), W'(0));
    chk("rst_done", W'({req0_done, req1_done}), W'(0));
    chk("rst_result0", req0_result, W'(0));
    chk("rst_result1", req1_result, W'(0));
    chk("rst_core_a", core_a, W'(0));
    chk("rst_core_e", core_e, W'(0));
    chk("rst_core_n", core_n, W'(0));
    chk("rst_ready", W'({req0_ready, req1_ready}), W'(0));

    for (int i = 0; i < 6; i++) run_job(vecs[i].req, vecs[i], 1'b0);

    // Stray core_finished in IDLE
    r0 = req0_result;
    r1 = req1_result;
    @(negedge avm_clk);
    spur_fin = 1'b1;
    @(negedge avm_clk);
    spur_fin = 1'b0;
    chk("spur_idle_busy", W'(busy), W'(0));
    chk("spur_idle_done", W'(req0_done | req1_done), W'(0));
    @(negedge avm_clk);
    chk("spur_idle_busy2", W'(busy), W'(0));
    chk("spur_idle_done2", W'(req0_done | req1_done), W'(0));
    chk("spur_idle_r0", req0_result, r0);
    chk("spur_idle_r1", req1_result, r1);

    // Stray core_finished in LAUNCH
    run_job(0, vecs[2], 1'b1);

    // Contention: both requesters keep three jobs pending
    pulse_reset();
`ifdef RSA_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 1, 1, 1};
`endif
    idx = '{0, 0};
    dn  = '{0, 0};
    for (int c = 0; c < 600 && (dn[0] + dn[1]) < 6; c++) begin
      @(negedge avm_clk);
      if (req0_done) begin
        chk("cont_done0_grant", W'(grant_id), W'(0));
        if (dn[0] < 3) chk("cont_result0", req0_result, vecs[2 * dn[0]].exp);
        dn[0]++;
      end
      if (req1_done) begin
        chk("cont_done1_grant", W'(grant_id), W'(1));
        if (dn[1] < 3) chk("cont_result1", req1_result, vecs[2 * dn[1] + 1].exp);
        dn[1]++;
      end
      if (idx[0] < 3) drive(0, vecs[2 * idx[0]], 1'b1);
      else            req0_valid = 1'b0;
      if (idx[1] < 3) drive(1, vecs[2 * idx[1] + 1], 1'b1);
      else            req1_valid = 1'b0;
      #1;
      if (req0_ready) begin order.push_back(0); idx[0]++; end
      if (req1_ready) begin order.push_back(1); idx[1]++; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont_grant_count", W'(order.size()), W'(6));
    chk("cont_done_count", W'(dn[0] + dn[1]), W'(6));
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("cont_order[%0d]", i), W'(order[i]), W'(exp_order[i]));

    // Reset in RUN abandons a req1 job
    @(negedge avm_clk);
    drive(1, vecs[5], 1'b1);
    wait_ready(1, ok);
    @(negedge avm_clk);
    req1_valid = 1'b0;
    repeat (3) @(negedge avm_clk);
    chk("pre_rst_busy", W'(busy), W'(1));
    avm_rst = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done1", W'(req1_done), W'(0));
    chk("midrst_result1", req1_result, W'(0));
    chk("midrst_result0", req0_result, W'(0));
    chk("midrst_grant_id", W'(grant_id), W'(0));
    chk("midrst_core_a", core_a, W'(0));
    @(negedge avm_clk);
    avm_rst = 1'b0;
    d = 0;
    repeat (20) begin
      @(negedge avm_clk);
      if (req0_done || req1_done || busy) d++;
    end
    chk("midrst_quiet", W'(d), W'(0));
    run_job(1, vecs[5], 1'b0);

    // Back-to-back: req1 waits through a req0 job
    d = starts;
    @(negedge avm_clk);
    drive(0, vecs[0], 1'b1);
    wait_ready(0, ok);
    @(negedge avm_clk);
    req0_valid = 1'b0;
    drive(1, vecs[1], 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req0_done) begin ok = 1'b1; break; end
      if (req1_ready) chk("b2b_early_ready1", W'(1), W'(0));
      @(negedge avm_clk);
    end
    chk("b2b_done0_seen", W'(ok), W'(1));
    chk("b2b_result0", req0_result, vecs[0].exp);
    chk("b2b_ready1_in_done", W'(req1_ready), W'(0));
    @(negedge avm_clk);
    #1;
    chk("b2b_ready1_first_idle", W'(req1_ready), W'(1));
    @(negedge avm_clk);
    req1_valid = 1'b0;
    chk("b2b_launch1", W'(core_start), W'(1));
    chk("b2b_grant1", W'(grant_id), W'(1));
    wait_done(1, ok);
    chk("b2b_result1", req1_result, vecs[1].exp);
    @(negedge avm_clk);
    chk("b2b_start_count", W'(starts - d), W'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_core_arbiter.md
RSA_CORE_ARBITER -- requirements
Module: rsa_core_arbiter

Interface
REQ-001 Parameter: WIDTH, 256, operand/result width in bits.
REQ-002 avm_clk  input  1  clock; reset avm_rst, asynchronous, active-high; clock avm_clk.
REQ-003 avm_rst  input  1  asynchronous active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester k has a job pending.
REQ-005 req0_ready / req1_ready  output  1  job accepted on the clock edge where valid&ready.
REQ-006 req0_a / req1_a  input  WIDTH  base operand.
REQ-007 req0_e / req1_e  input  WIDTH  exponent operand.
REQ-008 req0_n / req1_n  input  WIDTH  modulus operand.
REQ-009 req0_done / req1_done  output  1  one-cycle pulse, result valid.
REQ-010 req0_result / req1_result  output  WIDTH  result; held until that requester's next done.
REQ-011 core_start  output  1  one-cycle start pulse to the shared exponentiation core.
REQ-012 core_a, core_e, core_n  output  WIDTH  latched operands to the core.
REQ-013 core_result  input  WIDTH  core result, valid while core_finished=1.
REQ-014 core_finished  input  1  core completion pulse.
REQ-015 busy  output  1  high when state != IDLE.
REQ-016 grant_id  output  1  index of the requester currently owning the core.

Function
REQ-017 FSM states IDLE, LAUNCH, RUN, DONE; IDLE->LAUNCH on accept, LAUNCH->RUN unconditionally, RUN->DONE on core_finished, DONE->IDLE unconditionally.
REQ-018 reqk_ready is combinational: 1 only in IDLE for the arbitration winner k; 0 in all other states.
REQ-019 On accept edge, latch winner's a/e/n into core_a/e/n and set grant_id=k; operands stay stable through LAUNCH and RUN.
REQ-020 core_start=1 exactly during the LAUNCH cycle; never asserted in any other state.
REQ-021 In RUN, on core_finished=1 latch core_result into req<grant_id>_result; other requester's result unchanged.
REQ-022 In DONE, req<grant_id>_done=1 for exactly one cycle; other done stays 0.
REQ-023 Latency: accept at edge T -> core_start high in cycle T+1; core_finished in cycle F -> done high in cycle F+1; minimum 4 cycles from accept to IDLE.
REQ-024 core_finished outside RUN is ignored (no state change, no result write).
REQ-025 A valid arriving in LAUNCH/RUN/DONE waits; earliest accept is the first IDLE cycle.
REQ-026 Same requester re-asserting valid during its own DONE cycle is not accepted until the following IDLE cycle.
REQ-027 Requesters hold valid and operands stable until ready; valid dropped before accept leaves no state change.
REQ-028 Only one job outstanding on the core at any time; no queuing beyond the single operand latch.

Reset
REQ-029 On avm_rst: state=IDLE, core_start=0, busy=0, grant_id=0, both done=0, both result=0, core_a/e/n=0, round-robin pointer last=1.
REQ-030 Reset mid-job (LAUNCH/RUN/DONE) abandons the job with no done pulse; core is reset by the same avm_rst.
REQ-031 First accept after reset deasserts no earlier than the first avm_clk edge after avm_rst falls.

Configuration
REQ-032 Macro RSA_ARB_ROUND_ROBIN_EN defined: when both valid in IDLE, winner = requester not equal to last-served pointer; pointer updates to winner on each accept; single valid always wins.
REQ-033 Macro RSA_ARB_ROUND_ROBIN_EN undefined: fixed priority, req0 wins whenever req0_valid=1; pointer logic absent.

Verification
REQ-034 Single job: req0 a=4,e=13,n=497 valid, core model finishes 10 cycles after start -> req0_ready one cycle, core_start one cycle later, req0_done with req0_result=445, req1_done never.
REQ-035 Contention, RR enabled: both valid continuously, 3 jobs each -> grant order 0,1,0,1,0,1; each done to matching requester.
REQ-036 Contention, RR disabled: both valid, req0 issues 3 back-to-back jobs -> req1 not accepted until req0_valid drops.
REQ-037 Spurious core_finished pulsed in IDLE and LAUNCH -> no done, results unchanged, state unaffected.
REQ-038 avm_rst asserted in RUN for req1 job -> busy=0, no req1_done, req1_result=0; next req1 job completes normally.
REQ-039 Back-to-back: req1 valid held through req0 job -> req1 accepted in first IDLE cycle after req0_done, core_start exactly once per job.
